// File: rtl/program_loader.sv
// Host-side program loader: buffers a host stream, replays it, runs and waits.
// Optional running checksum of loaded words under LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int DEPTH          = 64,
   parameter int AW             = 6,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          host_valid,
   input  logic [31:0]   host_instr,
   input  logic          host_last,
   output logic          host_ready,
   output logic          add_into,
   output logic [31:0]   new_instruction,
   output logic          start_signal,
   input  logic          end_signal,
   input  logic [31:0]   debug1,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [31:0]   result,
   output logic [AW:0]   instr_count
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [31:0]   checksum
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_FEED, S_START, S_WAIT, S_DONE
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr, rptr, wbase;
   logic [TW-1:0] tcnt;
   logic [AW:0]   cnt_base;
   logic          ld_state, accept, first, last_word;
   logic          feed_last, end_hit, to_hit;

   assign ld_state  = (state == S_IDLE) || (state == S_LOAD) ||
                      (state == S_DONE);
   assign accept    = host_valid && ld_state;
   assign first     = accept && (state != S_LOAD);
   // A new program always restarts at slot 0 with an empty count.
   assign wbase     = first ? '0 : wptr;
   assign cnt_base  = first ? '0 : instr_count;
   assign last_word = host_last || (cnt_base == (AW+1)'(DEPTH - 1));
   assign feed_last = ({1'b0, rptr} + (AW+1)'(1)) == instr_count;
   assign end_hit   = (state == S_WAIT) && end_signal;
   assign to_hit    = (state == S_WAIT) && !end_signal &&
                      (tcnt == TW'(TIMEOUT_CYCLES - 1));

   assign new_instruction = add_into ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      host_ready   = 1'b0;
      add_into     = 1'b0;
      start_signal = 1'b0;
      busy         = 1'b0;
      unique case (state)
         S_IDLE, S_LOAD, S_DONE: begin
            host_ready = 1'b1;
            if (accept) state_nxt = last_word ? S_FEED : S_LOAD;
         end
         S_FEED: begin
            add_into = 1'b1;
            busy     = 1'b1;
            if (feed_last) state_nxt = S_START;
         end
         S_START: begin
            start_signal = 1'b1;
            busy         = 1'b1;
            state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            start_signal = 1'b1;
            busy         = 1'b1;
            if (end_signal || to_hit) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) mem[wbase] <= host_instr;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr        <= '0;
         rptr        <= '0;
         tcnt        <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         result      <= '0;
         instr_count <= '0;
      end else begin
         if (accept) begin
            wptr        <= wbase + AW'(1);
            instr_count <= cnt_base + (AW+1)'(1);
            if (first) begin
               rptr    <= '0;
               done    <= 1'b0;
               timeout <= 1'b0;
               result  <= '0;
            end
         end
         if (state == S_FEED)  rptr <= rptr + AW'(1);
         if (state == S_START) tcnt <= '0;
         if (state == S_WAIT)  tcnt <= tcnt + TW'(1);
         // A late end_signal on the limit cycle still counts as normal.
         if (end_hit) begin
            result <= debug1;
            done   <= 1'b1;
         end else if (to_hit) begin
            result  <= '0;
            timeout <= 1'b1;
            done    <= 1'b1;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset)       checksum <= '0;
      else if (first)  checksum <= host_instr;
      else if (accept) checksum <= checksum + host_instr;
   end
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader.
// Covers load/feed/run, timeout, implicit last, mid-run reset.
`timescale 1ns/1ps
module tb_program_loader;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_valid;
   logic [31:0] host_instr;
   logic        host_last;
   logic        host_ready;
   logic        add_into;
   logic [31:0] new_instruction;
   logic        start_signal;
   logic        end_signal;
   logic [31:0] debug1;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [31:0] result;
   logic [6:0]  instr_count;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   always #5 clk = ~clk;

   program_loader #(
      .DEPTH(64), .AW(6), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset),
      .host_valid(host_valid), .host_instr(host_instr),
      .host_last(host_last), .host_ready(host_ready),
      .add_into(add_into), .new_instruction(new_instruction),
      .start_signal(start_signal), .end_signal(end_signal),
      .debug1(debug1), .busy(busy), .done(done),
      .timeout(timeout), .result(result),
      .instr_count(instr_count)
`ifdef LOADER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   typedef struct {
      int          n;
      bit          last;
      logic [31:0] w0, w1, w2;
      int          end_dly;
      logic [31:0] dbg;
      logic [31:0] exp_res;
      bit          exp_to;
   } vec_t;

   vec_t vt[5];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] word(vec_t v, int i);
      if (i == 0) return v.w0;
      if (i == 1) return v.w1;
      if (i == 2) return v.w2;
      return 32'hA000_0000 + 32'(i * 7);
   endfunction

   task automatic load(vec_t v, output logic [31:0] sum);
      sum = '0;
      for (int i = 0; i < v.n; i++) begin
         host_valid = 1'b1;
         host_instr = word(v, i);
         host_last  = v.last && (i == v.n - 1);
         sum        = sum + host_instr;
         @(negedge clk);
         if (i == 0) begin
            chk("clr_done", {31'b0, done}, 32'd0);
            chk("clr_timeout", {31'b0, timeout}, 32'd0);
            chk("clr_result", result, 32'd0);
            chk("clr_count", {25'b0, instr_count}, 32'd1);
         end
      end
      // host keeps offering a word while busy; it must be held off
      host_valid = 1'b1;
      host_instr = 32'hDEAD_BEEF;
      host_last  = 1'b1;
      chk("ready_low", {31'b0, host_ready}, 32'd0);
   endtask

   task automatic run(vec_t v);
      logic [31:0] sum;
      int          j;
      bit          fin;
      load(v, sum);
      for (int k = 0; k < v.n; k++) begin
         chk("feed_valid", {31'b0, add_into}, 32'd1);
         chk("feed_word", new_instruction, word(v, k));
         @(negedge clk);
      end
      host_valid = 1'b0;
      host_last  = 1'b0;
      host_instr = '0;
      chk("feed_end", {31'b0, add_into}, 32'd0);
      chk("start_rise", {31'b0, start_signal}, 32'd1);
      @(negedge clk);
      chk("wait_start", {31'b0, start_signal}, 32'd1);
      chk("wait_busy", {31'b0, busy}, 32'd1);
      j   = 0;
      fin = 1'b0;
      while (!fin) begin
         if (v.end_dly != 0 && j == v.end_dly - 1) begin
            end_signal = 1'b1;
            debug1     = v.dbg;
         end
         @(negedge clk);
         j++;
         end_signal = 1'b0;
         debug1     = '0;
         if ((v.end_dly != 0 && j == v.end_dly) ||
             (v.end_dly == 0 && j == TO)) begin
            chk("done", {31'b0, done}, 32'd1);
            chk("timeout", {31'b0, timeout}, {31'b0, v.exp_to});
            chk("result", result, v.exp_res);
            chk("start_fall", {31'b0, start_signal}, 32'd0);
            chk("busy_fall", {31'b0, busy}, 32'd0);
            fin = 1'b1;
         end else if (v.end_dly == 0 && j == TO - 1) begin
            chk("no_early_to", {31'b0, done}, 32'd0);
         end else if (j > TO + 5) begin
            chk("wait_bound", {31'b0, done}, 32'd1);
            fin = 1'b1;
         end
      end
      chk("instr_count", {25'b0, instr_count}, 32'(v.n));
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", checksum, sum);
`endif
      end_signal = 1'b1;
      debug1     = 32'hFFFF_FFFF;
      @(negedge clk);
      end_signal = 1'b0;
      debug1     = '0;
      chk("end_ignored", result, v.exp_res);
      chk("done_sticky", {31'b0, done}, 32'd1);
   endtask

   initial begin
      vec_t vr, v1;
      logic [31:0] s;
      vt[0] = '{3, 1'b1, 32'h13, 32'h0010_0093, 32'h0, 20,
                32'h2A, 32'h2A, 1'b0};
      vt[1] = '{3, 1'b1, 32'h1, 32'h2, 32'hFFFF_FFFF, 5,
                32'h1234_5678, 32'h1234_5678, 1'b0};
      vt[2] = '{5, 1'b1, 32'h11, 32'h22, 32'h33, 0,
                32'h55, 32'h0, 1'b1};
      vt[3] = '{64, 1'b0, 32'h7, 32'h8, 32'h9, 1,
                32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
      vt[4] = '{1, 1'b1, 32'h0000_0073, 32'h0, 32'h0, 3,
                32'h1, 32'h1, 1'b0};
      vr = '{5, 1'b1, 32'hB1, 32'hB2, 32'hB3, 0, 32'h0, 32'h0, 1'b0};
      v1 = '{1, 1'b1, 32'h0040_0113, 32'h0, 32'h0, 2,
             32'h99, 32'h99, 1'b0};

      reset      = 1'b1;
      host_valid = 1'b0;
      host_instr = '0;
      host_last  = 1'b0;
      end_signal = 1'b0;
      debug1     = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", {31'b0, host_ready}, 32'd1);
      chk("rst_add", {31'b0, add_into}, 32'd0);
      chk("rst_instr", new_instruction, 32'd0);
      chk("rst_start", {31'b0, start_signal}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_timeout", {31'b0, timeout}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_count", {25'b0, instr_count}, 32'd0);

      for (int t = 0; t < 5; t++) run(vt[t]);

      load(vr, s);
      chk("mid_feed0", new_instruction, 32'hB1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      host_valid = 1'b0;
      host_last  = 1'b0;
      chk("mr_add", {31'b0, add_into}, 32'd0);
      chk("mr_start", {31'b0, start_signal}, 32'd0);
      chk("mr_ready", {31'b0, host_ready}, 32'd1);
      chk("mr_count", {25'b0, instr_count}, 32'd0);
      reset = 1'b0;
      run(v1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
